sm_addsub_pipe: RTL and testbench
=================================

SM_ADDSUB_PIPE -- requirements
Module: sm_addsub_pipe

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameter SHALL be: WIDTH, 16, total word width (bit WIDTH-1 = sign, bits WIDTH-2:0 = magnitude, sign-magnitude format).
REQ-003 Parameter SHALL be: SAT, 1, 1 = saturate on overflow, 0 = wrap magnitude modulo 2^(WIDTH-1).
REQ-004 Port SHALL be: clk  input  1  rising-edge clock.
REQ-005 Port SHALL be: rst  input  1  synchronous active-high reset.
REQ-006 Port SHALL be: in_valid  input  1  operand beat valid.
REQ-007 Port SHALL be: in_ready  output  1  block accepts a beat this cycle.
REQ-008 Port SHALL be: op  input  2  operation: 00 ADD, 01 SUB, 10 ACC, 11 LOAD.
REQ-009 Port SHALL be: a  input  WIDTH  operand A, sign-magnitude.
REQ-010 Port SHALL be: b  input  WIDTH  operand B, sign-magnitude (ignored for ACC and LOAD).
REQ-011 Port SHALL be: out_valid  output  1  result valid.
REQ-012 Port SHALL be: out_ready  input  1  downstream accepts the result.
REQ-013 Port SHALL be: c  output  WIDTH  result, sign-magnitude.
REQ-014 Port SHALL be: ovf  output  1  overflow flag for the result on c.

Function
REQ-015 A beat SHALL transfer on in_valid && in_ready, and a result SHALL transfer on out_valid && out_ready.
REQ-016 Operations SHALL be:
- ADD: c = a + b.
- SUB: c = a - b, where b's sign is inverted before addition.
- ACC: c = acc + a, then acc <= c.
- LOAD: c = a, then acc <= a, with ovf = 0.
REQ-017 The adder SHALL work in sign-magnitude:
- Equal signs: add magnitudes and keep the sign.
- Different signs: subtract the smaller magnitude from the larger and take the sign of the larger.
- Equal magnitudes with different signs: the result SHALL be +0.
REQ-018 A zero result SHALL always carry sign 0; input -0 (sign 1, magnitude 0) SHALL be treated as +0.
REQ-019 Overflow occurs when the magnitude sum exceeds 2^(WIDTH-1)-1, and ovf SHALL then be 1.
- SAT=1: magnitude = 2^(WIDTH-1)-1, with the correct sign.
- SAT=0: magnitude = low WIDTH-1 bits of the sum.
REQ-020 The pipeline SHALL have two register stages.
- Stage 1 registers op, a, b (with b sign-adjusted for SUB).
- Stage 2 computes, reads and writes acc, and registers c and ovf.
- Latency from accepted beat to out_valid SHALL be 2 cycles when out_ready is held 1.
REQ-021 Throughput SHALL be one beat per cycle when out_ready=1.
REQ-022 Stage 2 SHALL advance when it is empty or out_ready=1; stage 1 SHALL advance when it is empty or stage 2 advances.
REQ-023 in_ready SHALL equal !s1_valid || stage-2-advance, combinationally.
REQ-024 While out_valid=1 and out_ready=0, c, ovf and out_valid SHALL hold stable and acc SHALL NOT change.
REQ-025 acc SHALL be read and written only in stage 2, so back-to-back ACC beats need no forwarding and results SHALL be in program order.
REQ-026 An ACC result that overflows SHALL write the saturated (or wrapped) value into acc.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL reset as follows:
- s1_valid=0 and out_valid=0.
- c=0, ovf=0 and acc=+0.
- Any in-flight beats SHALL be discarded.
REQ-028 During rst=1, in_ready SHALL be 0.
REQ-029 In the first cycle after rst deasserts, in_ready SHALL be 1.

Structure
REQ-030 The op encodings (ADD, SUB, ACC, LOAD) SHALL be constants in the shared package used by the detector datapath.
REQ-031 The stage-2 combinational sign-magnitude add/saturate SHALL be one sub-module, sm_addsub_core, parametrised by WIDTH and SAT, with outputs sum and ovf.

Verification
REQ-032 With WIDTH=16, SAT=1, the bench SHALL check these cases:
- ADD a=0x0005, b=0x8003 -> c=0x0002, ovf=0, two cycles after acceptance.
- ADD a=0x8005, b=0x0005 -> c=0x0000 (+0).
- SUB a=0x0003, b=0x0005 -> c=0x8002.
REQ-033 ADD a=0x7FFF, b=0x0001 -> c=0x7FFF, ovf=1; the same case with SAT=0 -> c=0x0000, ovf=1.
REQ-034 LOAD 0x0010, then ACC 0x8004, then ACC 0x8020 on consecutive cycles -> c = 0x0010, 0x000C, 0x8014 in order, with final acc=0x8014.
REQ-035 Backpressure test:
- Stimulus: stream 4 ADD beats with out_ready=0 for 3 cycles, then 1.
- in_ready SHALL drop to 0 once both stages are full.
- c SHALL hold stable while stalled.
- All 4 results SHALL arrive in order with none lost or duplicated.
REQ-036 Reset mid-operation test:
- Stimulus: assert rst with both stages full and acc=0x0123.
- Next cycle: out_valid=0, acc=0.
- A following ACC 0x0001 SHALL yield c=0x0001.

Source files
------------

// File: rtl/sm_addsub_pipe_pkg.sv
// Shared constants and types for the sign-magnitude add/sub pipeline.
package sm_addsub_pipe_pkg;
  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;
endpackage

// File: rtl/sm_addsub_pipe_if.sv
// Operand/result handshake bundle for sm_addsub_pipe.
interface sm_addsub_pipe_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             ovf;

  modport master (output in_valid, op, a, b, out_ready,
                  input  in_ready, out_valid, c, ovf);
  modport slave  (input  in_valid, op, a, b, out_ready,
                  output in_ready, out_valid, c, ovf);
endinterface

// File: rtl/sm_addsub_pipe_core.sv
// Combinational sign-magnitude adder with saturate or wrap on overflow.
module sm_addsub_core #(
  parameter int WIDTH = 16,
  parameter int SAT   = 1
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);
  localparam int M = WIDTH - 1;

  logic [M-1:0] mx, my, mag;
  logic         sx, sy, sgn;
  logic [M:0]   raw;

  always_comb begin
    mx  = x[M-1:0];
    my  = y[M-1:0];
    // -0 on input behaves as +0
    sx  = x[M] & (|mx);
    sy  = y[M] & (|my);
    raw = {1'b0, mx} + {1'b0, my};
    ovf = 1'b0;
    sgn = sx;
    mag = raw[M-1:0];
    if (sx == sy) begin
      ovf = raw[M];
      if (raw[M] && (SAT != 0)) mag = '1;
    end else if (mx >= my) begin
      mag = mx - my;
    end else begin
      mag = my - mx;
      sgn = sy;
    end
    sum = {sgn & (|mag), mag};
  end
endmodule

// File: rtl/sm_addsub_pipe.sv
// Two-stage sign-magnitude ADD/SUB/ACC/LOAD pipeline with valid/ready flow control.
module sm_addsub_pipe
  import sm_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SAT   = 1
) (
  input  logic clk,
  input  logic rst,
  sm_addsub_pipe_if.slave bus
);
  logic             s1_valid_q;
  op_e              s1_op_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] c_q, acc_q;
  logic             ovf_q;

  logic             adv2, adv1;
  logic [WIDTH-1:0] b_adj, x, y, sum;
  logic             sum_ovf;

  assign adv2 = !out_valid_q || bus.out_ready;
  assign adv1 = !rst && (!s1_valid_q || adv2);
  assign out_valid_d = s1_valid_q;

  assign bus.in_ready  = adv1;
  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign bus.ovf       = ovf_q;

  always_comb begin
    b_adj = bus.b;
    if (op_e'(bus.op) == OP_SUB) b_adj[WIDTH-1] = ~bus.b[WIDTH-1];
  end

  // LOAD goes through the adder with y=0 so a -0 operand is normalised
  always_comb begin
    x = s1_a_q;
    y = s1_b_q;
    case (s1_op_q)
      OP_ACC:  begin x = acc_q; y = s1_a_q; end
      OP_LOAD: y = '0;
      default: ;
    endcase
  end

  sm_addsub_core #(.WIDTH(WIDTH), .SAT(SAT)) u_core (
    .x   (x),
    .y   (y),
    .sum (sum),
    .ovf (sum_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ADD;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      if (adv1) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_op_q <= op_e'(bus.op);
          s1_a_q  <= bus.a;
          s1_b_q  <= b_adj;
        end
      end
      if (adv2) begin
        out_valid_q <= out_valid_d;
        if (s1_valid_q) begin
          c_q   <= sum;
          ovf_q <= sum_ovf;
          if (s1_op_q == OP_ACC || s1_op_q == OP_LOAD) acc_q <= sum;
        end
      end
    end
  end
endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Directed self-checking bench for sm_addsub_pipe (SAT=1 and SAT=0 instances).
module tb_sm_addsub_pipe;
  import sm_addsub_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  sm_addsub_pipe_if #(.WIDTH(16)) i0 ();
  sm_addsub_pipe_if #(.WIDTH(16)) i1 ();

  assign i1.in_valid  = i0.in_valid;
  assign i1.op        = i0.op;
  assign i1.a         = i0.a;
  assign i1.b         = i0.b;
  assign i1.out_ready = i0.out_ready;

  sm_addsub_pipe #(.WIDTH(16), .SAT(1)) dut0 (.clk(clk), .rst(rst), .bus(i0.slave));
  sm_addsub_pipe #(.WIDTH(16), .SAT(0)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));

  logic [15:0] got_q[$];
  always @(posedge clk)
    if (!rst && i0.out_valid && i0.out_ready) got_q.push_back(i0.c);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input op_e op, input logic [15:0] a, input logic [15:0] b);
    i0.in_valid = 1'b1;
    i0.op       = op;
    i0.a        = a;
    i0.b        = b;
  endtask

  task automatic run1(input string tag, input op_e op, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] ec, input logic eovf);
    drive(op, a, b);
    @(posedge clk); #1;
    i0.in_valid = 1'b0;
    chk({tag, "_lat1"}, i0.out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_vld"}, i0.out_valid, 1);
    chk({tag, "_c"}, i0.c, ec);
    chk({tag, "_ovf"}, i0.ovf, eovf);
  endtask

  logic [15:0] bp_exp [4] = '{16'h0002, 16'h0004, 16'h0006, 16'h0008};

  initial begin
    int          k, base;
    logic        acc_now, stalled, saw_low;
    logic [15:0] prev_c;

    rst = 1'b1;
    i0.in_valid = 1'b0; i0.op = 2'b00; i0.a = '0; i0.b = '0; i0.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", i0.in_ready, 0);
    chk("rst_out_valid", i0.out_valid, 0);
    chk("rst_c", i0.c, 0);
    chk("rst_ovf", i0.ovf, 0);
    chk("rst_acc", dut0.acc_q, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", i0.in_ready, 1);
    @(posedge clk); #1;

    run1("add_mixed", OP_ADD, 16'h0005, 16'h8003, 16'h0002, 1'b0);
    run1("add_cancel", OP_ADD, 16'h8005, 16'h0005, 16'h0000, 1'b0);
    run1("sub_neg", OP_SUB, 16'h0003, 16'h0005, 16'h8002, 1'b0);
    run1("add_negzero", OP_ADD, 16'h8000, 16'h8000, 16'h0000, 1'b0);
    run1("add_sat", OP_ADD, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1);
    chk("add_wrap_c", i1.c, 16'h0000);
    chk("add_wrap_ovf", i1.ovf, 1);
    run1("add_negsat", OP_ADD, 16'hFFFF, 16'h8002, 16'hFFFF, 1'b1);
    chk("add_negwrap_c", i1.c, 16'h8001);

    // LOAD then two ACC beats back to back
    drive(OP_LOAD, 16'h0010, 16'h5555);
    @(posedge clk); #1;
    drive(OP_ACC, 16'h8004, 16'h0000);
    @(posedge clk); #1;
    chk("ld_c", i0.c, 16'h0010);
    chk("ld_ovf", i0.ovf, 0);
    drive(OP_ACC, 16'h8020, 16'h0000);
    @(posedge clk); #1;
    chk("acc1_c", i0.c, 16'h000C);
    i0.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("acc2_c", i0.c, 16'h8014);
    chk("acc2_vld", i0.out_valid, 1);
    chk("acc_final", dut0.acc_q, 16'h8014);
    @(posedge clk); #1;

    // backpressure: out_ready low for the first 3 cycles of the stream
    base = got_q.size();
    k = 0; stalled = 1'b0; saw_low = 1'b0; prev_c = '0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (stalled) begin
        chk("bp_hold_c", i0.c, prev_c);
        chk("bp_hold_vld", i0.out_valid, 1);
      end
      i0.out_ready = (cyc >= 3);
      if (k < 4) drive(OP_ADD, 16'(k + 1), 16'(k + 1));
      else i0.in_valid = 1'b0;
      #1;
      acc_now = i0.in_valid && i0.in_ready;
      if (!i0.in_ready) saw_low = 1'b1;
      stalled = i0.out_valid && !i0.out_ready;
      prev_c  = i0.c;
      @(posedge clk); #1;
      if (acc_now) k++;
    end
    i0.in_valid = 1'b0;
    chk("bp_in_ready_dropped", saw_low, 1);
    chk("bp_count", got_q.size() - base, 4);
    for (int j = 0; j < 4; j++)
      if (base + j < got_q.size()) chk($sformatf("bp_res%0d", j), got_q[base + j], bp_exp[j]);

    // reset with both stages occupied
    i0.out_ready = 1'b1;
    run1("ld123", OP_LOAD, 16'h0123, 16'h0000, 16'h0123, 1'b0);
    i0.out_ready = 1'b0;
    drive(OP_ADD, 16'h0001, 16'h0001);
    @(posedge clk); #1;
    i0.in_valid = 1'b0;
    chk("full_in_ready", i0.in_ready, 0);
    chk("full_acc", dut0.acc_q, 16'h0123);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_vld", i0.out_valid, 0);
    chk("mid_rst_acc", dut0.acc_q, 0);
    chk("mid_rst_in_ready", i0.in_ready, 0);
    rst = 1'b0;
    i0.out_ready = 1'b1;
    #1;
    chk("mid_rst_rdy_after", i0.in_ready, 1);
    run1("acc_after_rst", OP_ACC, 16'h0001, 16'h0000, 16'h0001, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
